// File: rtl/piano_pkg.sv
// Shared types and constants for the piano key front end.
package piano_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} gate_state_t;

    localparam int CLK_HZ = 50_000_000;

    // Counter width able to hold 0..terminal without wrapping.
    function automatic int cnt_width(input int terminal);
        return $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchroniser followed by a stable-time debouncer.
module key_debounce
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = CLK_HZ / 100
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic deb
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            deb    <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= key;
            sync_2 <= sync_1;
            // Any return to the accepted level restarts the stability window.
            if (sync_2 == deb) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                deb <= sync_2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_note_gate.sv
// Key-to-speaker gate: debounced keys, lowest-index priority, sustain tail.
// Optional volume PWM on the speaker output when VOLUME_PWM_EN is defined.
module key_note_gate
    import piano_pkg::*;
#(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = CLK_HZ / 100,
    parameter int SUSTAIN_CYCLES  = CLK_HZ / 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_KEYS-1:0]         keys,
    input  logic [NUM_KEYS-1:0]         note_in,
    input  logic [7:0]                  volume,
    output logic                        audio_out,
    output logic                        note_valid,
    output logic [$clog2(NUM_KEYS)-1:0] active_key
);

    localparam int KW = $clog2(NUM_KEYS);
    localparam int SW = cnt_width(SUSTAIN_CYCLES);
    localparam logic [SW-1:0] SUS_LAST = SW'(SUSTAIN_CYCLES - 1);

    logic [NUM_KEYS-1:0] deb_keys;
    logic [KW-1:0]       sel;
    logic                any;

    gate_state_t         state;
    gate_state_t         state_nxt;
    logic [KW-1:0]       key_nxt;
    logic [SW-1:0]       sus_cnt;
    logic [SW-1:0]       sus_nxt;
    logic                pwm_gate;
    logic                audio_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk   (clk),
                .reset (reset),
                .key   (keys[gi]),
                .deb   (deb_keys[gi])
            );
        end
    endgenerate

    // Scan downward so the lowest set index is the last assignment.
    always_comb begin
        sel = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (deb_keys[k]) sel = KW'(k);
        end
    end

    assign any = |deb_keys;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            active_key <= '0;
            sus_cnt    <= '0;
            note_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            active_key <= key_nxt;
            sus_cnt    <= sus_nxt;
            note_valid <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        key_nxt   = active_key;
        sus_nxt   = sus_cnt;
        case (state)
            IDLE: begin
                if (any) begin
                    state_nxt = PLAY;
                    key_nxt   = sel;
                end
            end
            PLAY: begin
                if (any) begin
                    key_nxt = sel;
                end else begin
                    state_nxt = RELEASE;
                    sus_nxt   = '0;
                end
            end
            RELEASE: begin
                // A new press takes priority over the tail expiring.
                if (any) begin
                    state_nxt = PLAY;
                    key_nxt   = sel;
                    sus_nxt   = '0;
                end else if (sus_cnt == SUS_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    sus_nxt = sus_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef VOLUME_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + 8'd1;
    end

    assign pwm_gate = (pwm_cnt < volume);
`else
    logic unused_volume;
    assign unused_volume = ^volume;
    assign pwm_gate      = 1'b1;
`endif

    // note_in is slow enough to be sampled directly here without a synchroniser.
    always_comb begin
        audio_nxt = (state != IDLE) & note_in[active_key] & pwm_gate;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) audio_out <= 1'b0;
        else       audio_out <= audio_nxt;
    end

endmodule
